// File: rtl/fifo_arb_pkg.sv
// Shared state type, default sizing and index helper for the FIFO write-port arbiter.
// Defaults describe the 8-entry, 8-bit FIFO shared by four producers.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_CNT_W     = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    localparam int ID_W = $clog2(DEF_NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Next producer index in round-robin order, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = ID_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    // Scan from furthest to nearest so the position closest to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(ptr) + k) % N);
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among producers,
// with registered write outputs and credit-based overflow protection.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    input  logic [CNT_W-1:0]           fifo_cnt,
    output logic                       fifo_wr,
    output logic [DATA_W-1:0]          fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   rr_nxt;
    logic [IW-1:0]   grant_nxt;
    logic [BW-1:0]   beat_cnt;
    logic [BW-1:0]   beat_nxt;
    logic [CNT_W:0]  space;
    logic            accept;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   sel;
    logic            xfer;
    logic [DATA_W-1:0] beat_data;

    // The pending write still counts against space since the FIFO has not seen it yet.
    assign space  = (CNT_W+1)'(DEPTH) - {1'b0, fifo_cnt} - {{CNT_W{1'b0}}, fifo_wr};
    assign accept = (space != '0) && !fifo_full;
    assign busy   = (state == BURST);

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    assign beat_data = req_data[int'(sel)*DATA_W +: DATA_W];

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        sel       = grant_id;
        xfer      = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (found && accept) begin
                    sel             = pick;
                    xfer            = 1'b1;
                    req_ready[pick] = 1'b1;
                    grant_nxt       = pick;
                    beat_nxt        = BW'(1);
                    if (MAX_BURST == 1) begin
                        rr_nxt = IW'(wrap_inc(int'(pick), NUM_REQ));
                    end else begin
                        state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                // Owner going idle ends the burst; a credit stall keeps ownership.
                if (!req_valid[grant_id]) begin
                    state_nxt = IDLE;
                    rr_nxt    = IW'(wrap_inc(int'(grant_id), NUM_REQ));
                end else if (accept) begin
                    xfer                = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    beat_nxt            = beat_cnt + 1'b1;
                    if (int'(beat_cnt) + 1 == MAX_BURST) begin
                        state_nxt = IDLE;
                        rr_nxt    = IW'(wrap_inc(int'(grant_id), NUM_REQ));
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            beat_cnt     <= '0;
            grant_id     <= '0;
            fifo_wr      <= 1'b0;
            fifo_data_in <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= beat_nxt;
            grant_id <= grant_nxt;
            fifo_wr  <= xfer;
            if (xfer) begin
                fifo_data_in <= beat_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, async-reset sequence and
// randomized traffic against a behavioural arbitration model and FIFO occupancy model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = DEF_NUM_REQ;
    localparam int DW    = DEF_DATA_W;
    localparam int CW    = DEF_CNT_W;
    localparam int DEPTH = DEF_DEPTH;
    localparam int MB    = DEF_MAX_BURST;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              fifo_full = 1'b0;
    logic [CW-1:0]     fifo_cnt = '0;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_data_in;
    logic [ID_W-1:0]   grant_id;
    logic              busy;

    fifo_wr_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_cnt     (fifo_cnt),
        .fifo_wr      (fifo_wr),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rst_first;
        logic [N-1:0] valid;
        int           cnt;
        bit           full;
        logic [N-1:0] exp_ready;
        bit           exp_wr;
        int           exp_grant;
        bit           exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   seq[N];

    // Model: owner holds the port for up to MB beats; otherwise first valid from ptr wins.
    bit           m_busy, m_wr, nx_busy, nx_wr;
    int           m_grant, m_ptr, m_beats, nx_grant, nx_ptr, nx_beats;
    logic [DW-1:0] m_data, nx_data;
    int           xfer_id;
    logic [N-1:0] exp_ready;

    function automatic logic [DW-1:0] prod_data(input int i);
        return DW'(8'h10 + 8'h40 * i + seq[i]);
    endfunction

    function automatic bit vbit(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic void add_row(input bit r, input logic [N-1:0] v, input int cnt, input bit full,
                                    input logic [N-1:0] rdy, input bit wr, input int g, input bit b);
        vec_t t;
        t.rst_first = r; t.valid = v; t.cnt = cnt; t.full = full;
        t.exp_ready = rdy; t.exp_wr = wr; t.exp_grant = g; t.exp_busy = b;
        vecs.push_back(t);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input int cnt, input bit full);
        req_valid = v;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = prod_data(i);
        fifo_cnt  = CW'(cnt);
        fifo_full = full;
    endtask

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_grant = 0; m_ptr = 0; m_beats = 0; m_data = '0;
        for (int i = 0; i < N; i++) seq[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        applyStimulus('0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic model_check();
        int space, cand;
        bit accept;
        checkOutput("fifo_wr", 32'(fifo_wr), 32'(m_wr));
        checkOutput("fifo_data_in", 32'(fifo_data_in), 32'(m_data));
        checkOutput("grant_id", 32'(grant_id), m_grant);
        checkOutput("busy", 32'(busy), 32'(m_busy));
        space  = (DEPTH - int'(fifo_cnt) - int'(m_wr)) & ((1 << (CW + 1)) - 1);
        accept = (space != 0) && !fifo_full;
        nx_busy = m_busy; nx_grant = m_grant; nx_ptr = m_ptr; nx_beats = m_beats; nx_data = m_data;
        xfer_id = -1;
        if (!m_busy) begin
            cand = -1;
            for (int k = 0; k < N; k++)
                if (cand < 0 && vbit(req_valid, (m_ptr + k) % N)) cand = (m_ptr + k) % N;
            if (cand >= 0 && accept) begin
                xfer_id = cand; nx_grant = cand; nx_beats = 1;
                if (MB == 1) nx_ptr = (cand + 1) % N;
                else nx_busy = 1;
            end
        end else if (vbit(req_valid, m_grant)) begin
            if (accept) begin
                xfer_id = m_grant; nx_beats = m_beats + 1;
                if (nx_beats == MB) begin nx_busy = 0; nx_ptr = (m_grant + 1) % N; end
            end
        end else begin
            nx_busy = 0; nx_ptr = (m_grant + 1) % N;
        end
        exp_ready = '0;
        if (xfer_id >= 0) begin
            exp_ready = N'(1) << xfer_id;
            nx_data = prod_data(xfer_id);
        end
        nx_wr = (xfer_id >= 0);
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    endtask

    task automatic advance();
        if (xfer_id >= 0) seq[xfer_id]++;
        m_busy = nx_busy; m_grant = nx_grant; m_ptr = nx_ptr; m_beats = nx_beats;
        m_wr = nx_wr; m_data = nx_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fcnt;
        bit rd;
        logic [N-1:0] v;

        // Single producer streams 6 beats then goes idle.
        add_row(1, 4'b0001, 0, 0, 4'b0001, 0, 0, 0);
        add_row(0, 4'b0001, 0, 0, 4'b0001, 1, 0, 1);
        add_row(0, 4'b0001, 0, 0, 4'b0001, 1, 0, 1);
        add_row(0, 4'b0001, 0, 0, 4'b0001, 1, 0, 1);
        add_row(0, 4'b0001, 0, 0, 4'b0001, 1, 0, 0);
        add_row(0, 4'b0001, 0, 0, 4'b0001, 1, 0, 1);
        add_row(0, 4'b0000, 0, 0, 4'b0000, 1, 0, 1);
        add_row(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        // All producers valid, FIFO drained: four-beat bursts rotating 0,1,2,3,0.
        for (int c = 0; c < 18; c++)
            add_row(c == 0, 4'b1111, 0, 0, N'(1) << ((c / 4) % 4), c >= 1,
                    (c == 0) ? 0 : ((c - 1) / 4) % 4, (c % 4) != 0);
        // Credit limit with one slot left.
        add_row(1, 4'b0001, 7, 0, 4'b0001, 0, 0, 0);
        add_row(0, 4'b0001, 7, 0, 4'b0000, 1, 0, 1);
        add_row(0, 4'b0001, 6, 0, 4'b0001, 0, 0, 1);
        add_row(0, 4'b0001, 7, 0, 4'b0000, 1, 0, 1);
        add_row(0, 4'b0001, 8, 1, 4'b0000, 0, 0, 1);
        // Full flag overrides an empty count.
        add_row(1, 4'b1111, 0, 1, 4'b0000, 0, 0, 0);
        add_row(0, 4'b1111, 0, 1, 4'b0000, 0, 0, 0);
        add_row(0, 4'b1111, 0, 1, 4'b0000, 0, 0, 0);
        // Owner 1 drops valid after two beats; producer 2 follows after one bubble.
        add_row(1, 4'b0110, 0, 0, 4'b0010, 0, 0, 0);
        add_row(0, 4'b0110, 0, 0, 4'b0010, 1, 1, 1);
        add_row(0, 4'b0100, 0, 0, 4'b0000, 1, 1, 1);
        add_row(0, 4'b0100, 0, 0, 4'b0100, 0, 1, 0);
        add_row(0, 4'b0100, 0, 0, 4'b0100, 1, 2, 1);

        $display("[TB] directed vectors: %0d rows", vecs.size());
        foreach (vecs[r]) begin
            if (vecs[r].rst_first) begin
                do_reset();
                checkOutput($sformatf("row%0d_rst_data", r), 32'(fifo_data_in), 32'h0);
            end
            applyStimulus(vecs[r].valid, vecs[r].cnt, vecs[r].full);
            #1;
            model_check();
            checkOutput($sformatf("row%0d_ready", r), 32'(req_ready), 32'(vecs[r].exp_ready));
            checkOutput($sformatf("row%0d_wr", r), 32'(fifo_wr), 32'(vecs[r].exp_wr));
            checkOutput($sformatf("row%0d_grant", r), 32'(grant_id), vecs[r].exp_grant);
            checkOutput($sformatf("row%0d_busy", r), 32'(busy), 32'(vecs[r].exp_busy));
            advance();
        end

        // Reset lands mid-burst: owner 3 after two beats.
        do_reset();
        repeat (2) begin
            applyStimulus(4'b1000, 0, 1'b0);
            #1;
            model_check();
            advance();
        end
        applyStimulus(4'b1000, 0, 1'b0);
        #1;
        model_check();
        checkOutput("midburst_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_wr", 32'(fifo_wr), 32'h0);
        checkOutput("async_rst_busy", 32'(busy), 32'h0);
        checkOutput("async_rst_grant", 32'(grant_id), 32'h0);
        checkOutput("async_rst_data", 32'(fifo_data_in), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        applyStimulus(4'b1001, 0, 1'b0);
        #1;
        model_check();
        checkOutput("restart_ready", 32'(req_ready), 32'h1);
        advance();
        applyStimulus(4'b1001, 0, 1'b0);
        #1;
        model_check();
        checkOutput("restart_grant", 32'(grant_id), 32'h0);
        advance();

        // Random traffic against a FIFO whose count follows the observed writes.
        do_reset();
        fcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 7);
            applyStimulus(v, fcnt, fcnt == DEPTH);
            #1;
            model_check();
            checkOutput("overflow", 32'(fifo_wr && (fcnt == DEPTH)), 32'h0);
            rd = (fcnt > 0) && ($urandom_range(0, 9) < 4);
            fcnt = fcnt + int'(fifo_wr) - int'(rd);
            if (fcnt > DEPTH) fcnt = DEPTH;
            if (fcnt < 0) fcnt = 0;
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
